// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit: signed and unsigned MULT/DIV,
// 33-cycle latency, results held on hi/lo until the next completion.
module mult_div_unit #(
    parameter logic [31:0] DIV0_QUOT = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [1:0]  op_q;
    logic [31:0] opnd;
    logic [31:0] a_raw;
    logic        sign_a;
    logic        sign_b;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        in_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        is_div;
    logic        is_signed;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_trial;
    logic [63:0] div_step;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    assign in_signed = ~op[0];
    assign a_abs     = (in_signed && operand_a[31]) ? -operand_a : operand_a;
    assign b_abs     = (in_signed && operand_b[31]) ? -operand_b : operand_b;
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign busy      = (state != IDLE);

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_step = {mul_sum, acc[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    assign div_trial = acc[63:31] - {1'b0, opnd};
    assign div_step  = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};

    assign prod = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
    assign quot = (is_signed && (sign_a ^ sign_b)) ? -acc[31:0] : acc[31:0];
    assign rem  = (is_signed && sign_a) ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == 5'd31) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q        <= 2'b00;
            opnd        <= 32'd0;
            a_raw       <= 32'd0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            cnt         <= 5'd0;
            acc         <= 64'd0;
            done        <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        opnd        <= op[1] ? b_abs : a_abs;
                        acc         <= {32'd0, op[1] ? a_abs : b_abs};
                        a_raw       <= operand_a;
                        sign_a      <= in_signed & operand_a[31];
                        sign_b      <= in_signed & operand_b[31];
                        cnt         <= 5'd0;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_step : mul_step;
                    cnt <= cnt + 5'd1;
                end
                FIN: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end else if (opnd == 32'd0) begin
                        hi          <= a_raw;
                        lo          <= DIV0_QUOT;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Each scenario task drives stimulus and checks results inline.
module tb_mult_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.DIV0_QUOT(32'hFFFFFFFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op, scramble inputs after the accepting edge, wait for done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output int busy_cyc);
        @(negedge clk);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op        = 2'($urandom_range(0, 3));
        lat       = 0;
        busy_cyc  = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) busy_cyc++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op = OP_MULTU;
        operand_a = 32'd5;
        operand_b = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000",
                     {busy, done, div_by_zero});
        end
        checks++;
        if ({hi, lo} !== 64'd0) begin
            errors++;
            $display("FAIL reset_hilo: got %h want 0", {hi, lo});
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored: busy=%b want 0", busy);
        end
    endtask

    task automatic test_multu();
        int lat, bc;
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL multu_latency: got %0d want 33", lat);
        end
        checks++;
        if (bc !== 33) begin
            errors++;
            $display("FAIL multu_busy_cycles: got %0d want 33", bc);
        end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            errors++;
            $display("FAIL multu_ffff: got %h want FFFFFFFE00000001",
                     {hi, lo});
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || {hi, lo} !== 64'hFFFFFFFE_00000001) begin
            errors++;
            $display("FAIL multu_done_pulse_hold: done=%b hilo=%h want 0/FFFFFFFE00000001",
                     done, {hi, lo});
        end
    endtask

    task automatic test_mult();
        int lat, bc;
        do_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB || lat !== 33) begin
            errors++;
            $display("FAIL mult_neg3x7: got %h lat %0d want FFFFFFFFFFFFFFEB lat 33",
                     {hi, lo}, lat);
        end
        do_op(OP_MULT, 32'h80000000, 32'h80000000, lat, bc);
        checks++;
        if ({hi, lo} !== 64'h40000000_00000000) begin
            errors++;
            $display("FAIL mult_minxmin: got %h want 4000000000000000",
                     {hi, lo});
        end
        do_op(OP_MULT, 32'd1234, 32'hFFFFFFFF, lat, bc);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFB2E) begin
            errors++;
            $display("FAIL mult_1234xneg1: got %h want FFFFFFFFFFFFFB2E",
                     {hi, lo});
        end
    endtask

    task automatic test_div();
        int lat, bc;
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || lat !== 33) begin
            errors++;
            $display("FAIL div_neg7by2: got lo=%h hi=%h lat %0d want FFFFFFFD FFFFFFFF 33",
                     lo, hi, lat);
        end
        do_op(OP_DIVU, 32'hFFFFFFF9, 32'd2, lat, bc);
        checks++;
        if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin
            errors++;
            $display("FAIL divu_fff9by2: got lo=%h hi=%h want 7FFFFFFC 00000001",
                     lo, hi);
        end
        do_op(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bc);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
            errors++;
            $display("FAIL div_7byneg2: got lo=%h hi=%h want FFFFFFFD 00000001",
                     lo, hi);
        end
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        checks++;
        if (lo !== 32'h80000000 || hi !== 32'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_overflow: got lo=%h hi=%h dbz=%b want 80000000 0 0",
                     lo, hi, div_by_zero);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        do_op(OP_DIVU, 32'd100, 32'd0, lat, bc);
        checks++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'h64 || div_by_zero !== 1'b1
            || lat !== 33) begin
            errors++;
            $display("FAIL divu_by0: got lo=%h hi=%h dbz=%b lat %0d want FFFFFFFF 64 1 33",
                     lo, hi, div_by_zero, lat);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_sticky: got %b want 1", div_by_zero);
        end
        do_op(OP_DIV, 32'hFFFFFFF6, 32'd0, lat, bc);
        checks++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF6 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL div_neg_by0: got lo=%h hi=%h dbz=%b want FFFFFFFF FFFFFFF6 1",
                     lo, hi, div_by_zero);
        end
        do_op(OP_DIVU, 32'd100, 32'd7, lat, bc);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL divu_100by7: got lo=%h hi=%h dbz=%b want e 2 0",
                     lo, hi, div_by_zero);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(OP_MULTU, 32'd3, 32'd5, lat, bc);
        do_op(OP_MULTU, 32'd11, 32'd13, lat, bc);
        checks++;
        if (lo !== 32'd143 || hi !== 32'd0 || lat !== 33) begin
            errors++;
            $display("FAIL back_to_back: got lo=%0d hi=%0d lat %0d want 143 0 33",
                     lo, hi, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        op = OP_MULTU;
        operand_a = 32'h00010000;
        operand_b = 32'h00030000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lat == 4) begin
                op = OP_DIVU;
                operand_a = 32'd99;
                operand_b = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
        checks++;
        if (hi !== 32'd3 || lo !== 32'd0 || lat !== 33) begin
            errors++;
            $display("FAIL start_while_busy: got hi=%h lo=%h lat %0d want 3 0 33",
                     hi, lo, lat);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_while_busy_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int lat, bc, seen;
        @(negedge clk);
        op = OP_DIV;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
                     busy, done, div_by_zero, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d active cycles want 0", seen);
        end
        do_op(OP_MULTU, 32'd6, 32'd7, lat, bc);
        checks++;
        if (lo !== 32'd42 || hi !== 32'd0 || lat !== 33) begin
            errors++;
            $display("FAIL post_reset_6x7: got lo=%0d hi=%0d lat %0d want 42 0 33",
                     lo, hi, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        operand_a = 32'd0;
        operand_b = 32'd0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_start_while_busy();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL take parameter DIV0_QUOT, default 32'hFFFFFFFF, as the quotient (lo) returned on divide-by-zero.
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 The block SHALL have port operand_a, input, 32 bits, fed from register file read_data1 (multiplicand / dividend).
REQ-007 The block SHALL have port operand_b, input, 32 bits, fed from register file read_data2 (multiplier / divisor).
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-010 The block SHALL have port hi, output, 32 bits: product[63:32] or remainder.
REQ-011 The block SHALL have port lo, output, 32 bits: product[31:0] or quotient.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit, a sticky flag for the last operation.

Function
REQ-013 The block SHALL implement the states IDLE, CALC and FIN; busy SHALL be 1 exactly when state is not IDLE.
REQ-014 In IDLE with start=1 at edge N, the block SHALL latch op, the operand magnitudes (abs for signed ops) and the sign bits, clear the iteration counter, clear div_by_zero, and enter CALC.
REQ-015 In CALC, the block SHALL perform one radix-2 iteration per edge (shift-add multiply or restoring divide) for edges N+1..N+32, and enter FIN at edge N+32 when the 5-bit counter wraps from 31.
REQ-016 At edge N+33 in FIN, the block SHALL apply sign correction, update hi/lo, set done=1 for exactly one cycle and return to IDLE.
REQ-017 done SHALL be 0 in every other cycle, and hi/lo SHALL hold their values until the next FIN.
REQ-018 start SHALL be ignored while busy=1; start in the cycle done=1 (IDLE) SHALL be accepted.
REQ-019 Operands SHALL be sampled only at the accepting edge; later changes on operand_a/b or op SHALL have no effect.
REQ-020 For MULT, the product sign SHALL be sign_a^sign_b, with 64-bit two's-complement negation of the magnitude product.
REQ-021 For DIV, the quotient sign SHALL be sign_a^sign_b and the remainder sign SHALL be sign_a (truncating division).
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0, with no flag.
REQ-023 For DIV/DIVU with operand_b=0, the block SHALL keep the same 33-cycle latency and produce lo=DIV0_QUOT, hi=operand_a (unsigned, uncorrected) and div_by_zero=1 from FIN until the next accepted start.
REQ-024 All arithmetic SHALL be on 32-bit magnitudes with a 64-bit accumulator; no result bit SHALL be lost.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0, div_by_zero=0 and counter=0, regardless of state.
REQ-026 Reset mid-operation SHALL abandon the operation, with no done pulse and hi/lo cleared.
REQ-027 start while rst_n=0 SHALL be ignored.
REQ-028 The first start accepted after rst_n returns high SHALL complete normally with 33-cycle latency.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF SHALL give hi=0xFFFFFFFE and lo=0x00000001, with done high exactly 33 edges after the start edge and busy high for the 33 cycles before it.
REQ-030 MULT 0xFFFFFFFD (-3) x 7 SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFEB (-21); MULT 0x80000000 x 0x80000000 SHALL give hi=0x40000000 and lo=0.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU 0xFFFFFFF9 / 2 SHALL give lo=0x7FFFFFFC and hi=1.
REQ-032 DIVU 100 / 0 SHALL give lo=0xFFFFFFFF, hi=0x00000064 and div_by_zero=1; a following DIVU 100 / 7 SHALL give lo=14, hi=2 and div_by_zero=0.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-034 A start with new operands pulsed at cycle 5 of a busy MULTU SHALL be ignored and the original result delivered.
REQ-035 rst_n=0 at cycle 10 of a busy DIV SHALL give all outputs 0 and no done pulse, and the next MULTU 6 x 7 SHALL give lo=42 and hi=0.
